// File: rtl/ram_dual_read_port_pkg.sv
// Shared datapath width definitions for the mini-ALU (ROM, ALU and RAM
// import these so that word and address widths always agree).
//
// Contents:
//   RAM_DATA_WIDTH - data word width in bits
//   RAM_ADDR_WIDTH - data memory address width in bits
//   RAM_MEM_DEPTH  - number of data memory words (2**RAM_ADDR_WIDTH)
//   ram_word_t     - one data memory word
//   ram_addr_t     - one data memory address
package ram_dual_read_port_pkg;

  localparam int RAM_DATA_WIDTH = 16;
  localparam int RAM_ADDR_WIDTH = 8;
  localparam int RAM_MEM_DEPTH  = 2 ** RAM_ADDR_WIDTH;

  typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;
  typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;

endpackage

// File: rtl/ram_dual_read_port_reg_sync_reset.sv
// reg_sync_reset: parameterized-width rising-edge register with a
// synchronous active-high reset and a load enable. Used for the read
// output registers of the data memory.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (priority over en)
//   en    - load d on the rising edge
//   d     - data in
//   q     - registered data out (0 at time 0 and after reset)
module reg_sync_reset
  import ram_dual_read_port_pkg::*;
#(
  parameter int WIDTH = RAM_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Initializer gives a defined power-up value in simulation and on
  // FPGA targets before the first reset.
  logic [WIDTH-1:0] q_reg = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ram_dual_read_port.sv
// ram_dual_read_port: mini-ALU data memory. MEM_DEPTH x DATA_WIDTH words,
// two independent registered read ports (1-cycle latency, read-first on
// collision with a write) and one synchronous write port. A multiply
// result can additionally store its high half at write address + 1
// (wrapping) when built with RAM_MUL_HIGH_WRITE_EN defined; otherwise
// iMulEnable/iParteAlta are accepted but ignored.
//
// Ports:
//   Clock          - clock, all state updates on the rising edge
//   Reset          - synchronous active-high; clears outputs and all words,
//                    discards any write on the same edge
//   iWriteEnable   - write iDataIn at iWriteAddress
//   iReadAddress0  - read port 0 address
//   iReadAddress1  - read port 1 address
//   iWriteAddress  - primary write address
//   iDataIn        - primary write data (low product half on multiply)
//   iMulEnable     - also write iParteAlta at iWriteAddress+1 (needs iWriteEnable)
//   iParteAlta     - high product half
//   oDataOut0      - registered read data, port 0
//   oDataOut1      - registered read data, port 1
//
// Build option: RAM_MUL_HIGH_WRITE_EN enables the high-part write.
module ram_dual_read_port
  import ram_dual_read_port_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int MEM_DEPTH  = 2 ** ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iReadAddress0,
  input  logic [ADDR_WIDTH-1:0] iReadAddress1,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  input  logic                  iMulEnable,
  input  logic [DATA_WIDTH-1:0] iParteAlta,
  output logic [DATA_WIDTH-1:0] oDataOut0,
  output logic [DATA_WIDTH-1:0] oDataOut1
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0] high_addr;
  logic                  high_write;
  logic [DATA_WIDTH-1:0] rd_data0;
  logic [DATA_WIDTH-1:0] rd_data1;

  // Address is exactly ADDR_WIDTH bits, so the +1 wraps 255 -> 0 naturally.
  assign high_addr = iWriteAddress + 1'b1;

`ifdef RAM_MUL_HIGH_WRITE_EN
  assign high_write = iWriteEnable & iMulEnable;
`else
  assign high_write = 1'b0;
  logic unused_mul;
  assign unused_mul = iMulEnable ^ (^iParteAlta);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (iWriteEnable) begin
        mem[iWriteAddress] <= iDataIn;
      end
      if (high_write) begin
        mem[high_addr] <= iParteAlta;
      end
    end
  end

  // Reads sample the array before this edge's write lands: read-first.
  assign rd_data0 = mem[iReadAddress0];
  assign rd_data1 = mem[iReadAddress1];

  reg_sync_reset #(.WIDTH(DATA_WIDTH)) u_out0 (
    .clk (Clock),
    .rst (Reset),
    .en  (1'b1),
    .d   (rd_data0),
    .q   (oDataOut0)
  );

  reg_sync_reset #(.WIDTH(DATA_WIDTH)) u_out1 (
    .clk (Clock),
    .rst (Reset),
    .en  (1'b1),
    .d   (rd_data1),
    .q   (oDataOut1)
  );

endmodule

// File: tb/tb_ram_dual_read_port.sv
// Directed self-checking bench for ram_dual_read_port.
module tb_ram_dual_read_port;

  logic        Clock;
  logic        Reset;
  logic        iWriteEnable;
  logic [7:0]  iReadAddress0;
  logic [7:0]  iReadAddress1;
  logic [7:0]  iWriteAddress;
  logic [15:0] iDataIn;
  logic        iMulEnable;
  logic [15:0] iParteAlta;
  logic [15:0] oDataOut0;
  logic [15:0] oDataOut1;

  int checks = 0;
  int fails  = 0;

  logic [15:0] exp_hi_21;
  logic [15:0] exp_hi_00;

  ram_dual_read_port dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iWriteEnable  (iWriteEnable),
    .iReadAddress0 (iReadAddress0),
    .iReadAddress1 (iReadAddress1),
    .iWriteAddress (iWriteAddress),
    .iDataIn       (iDataIn),
    .iMulEnable    (iMulEnable),
    .iParteAlta    (iParteAlta),
    .oDataOut0     (oDataOut0),
    .oDataOut1     (oDataOut1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
`ifdef RAM_MUL_HIGH_WRITE_EN
    exp_hi_21 = 16'h1234;
    exp_hi_00 = 16'hBABE;
`else
    exp_hi_21 = 16'h0000;
    exp_hi_00 = 16'h0000;
`endif

    // Reset with a write request active
    Reset = 1'b1; iWriteEnable = 1'b1; iWriteAddress = 8'h30; iDataIn = 16'hAAAA;
    iMulEnable = 1'b1; iParteAlta = 16'h5555;
    iReadAddress0 = 8'h30; iReadAddress1 = 8'h31;
    step(); step();
    chk("reset_out0", oDataOut0, 16'h0000);
    chk("reset_out1", oDataOut1, 16'h0000);

    Reset = 1'b0; iWriteEnable = 1'b0; iMulEnable = 1'b0;
    iReadAddress0 = 8'h00; iReadAddress1 = 8'h7F;
    step();
    chk("rd_after_rst_00", oDataOut0, 16'h0000);
    chk("rd_after_rst_7f", oDataOut1, 16'h0000);
    iReadAddress0 = 8'hFF; iReadAddress1 = 8'h30;
    step();
    chk("rd_after_rst_ff", oDataOut0, 16'h0000);
    chk("rd_after_rst_30", oDataOut1, 16'h0000);

    // Write then dual read
    iWriteEnable = 1'b1; iWriteAddress = 8'h05; iDataIn = 16'h1234;
    step();
    iWriteAddress = 8'h06; iDataIn = 16'hBEEF;
    step();
    iWriteEnable = 1'b0; iReadAddress0 = 8'h05; iReadAddress1 = 8'h06;
    step();
    chk("dual_rd0", oDataOut0, 16'h1234);
    chk("dual_rd1", oDataOut1, 16'hBEEF);
    iReadAddress0 = 8'h06; iReadAddress1 = 8'h06;
    #2;
    chk("hold_out0", oDataOut0, 16'h1234);
    step();
    chk("same_addr0", oDataOut0, 16'hBEEF);
    chk("same_addr1", oDataOut1, 16'hBEEF);

    // Read-first collision
    iWriteEnable = 1'b1; iWriteAddress = 8'h10; iDataIn = 16'h0001;
    step();
    iDataIn = 16'h0002; iReadAddress0 = 8'h10; iReadAddress1 = 8'h10;
    step();
    chk("collide_old0", oDataOut0, 16'h0001);
    chk("collide_old1", oDataOut1, 16'h0001);
    iWriteEnable = 1'b0;
    step();
    chk("collide_new", oDataOut0, 16'h0002);

    // Multiply write
    iWriteEnable = 1'b1; iMulEnable = 1'b1; iWriteAddress = 8'h20;
    iDataIn = 16'h5678; iParteAlta = 16'h1234;
    step();
    iWriteEnable = 1'b0; iMulEnable = 1'b0;
    iReadAddress0 = 8'h20; iReadAddress1 = 8'h21;
    step();
    chk("mul_low_20", oDataOut0, 16'h5678);
    chk("mul_high_21", oDataOut1, exp_hi_21);

    // Multiply write wrapping at top of memory
    iWriteEnable = 1'b1; iMulEnable = 1'b1; iWriteAddress = 8'hFF;
    iDataIn = 16'hCAFE; iParteAlta = 16'hBABE;
    step();
    iWriteEnable = 1'b0; iMulEnable = 1'b0;
    iReadAddress0 = 8'hFF; iReadAddress1 = 8'h00;
    step();
    chk("mul_low_ff", oDataOut0, 16'hCAFE);
    chk("mul_high_wrap_00", oDataOut1, exp_hi_00);

    // Multiply gating: no write without iWriteEnable
    iWriteEnable = 1'b0; iMulEnable = 1'b1; iWriteAddress = 8'h40;
    iDataIn = 16'h1111; iParteAlta = 16'h2222;
    step();
    iMulEnable = 1'b0; iReadAddress0 = 8'h40; iReadAddress1 = 8'h41;
    step();
    chk("gate_40", oDataOut0, 16'h0000);
    chk("gate_41", oDataOut1, 16'h0000);

    // Reset priority over a simultaneous write; clears all words
    iReadAddress0 = 8'h05; iReadAddress1 = 8'h20;
    Reset = 1'b1; iWriteEnable = 1'b1; iWriteAddress = 8'h30; iDataIn = 16'hAAAA;
    step();
    chk("rst_mid_out0", oDataOut0, 16'h0000);
    chk("rst_mid_out1", oDataOut1, 16'h0000);
    Reset = 1'b0; iWriteEnable = 1'b0;
    iReadAddress0 = 8'h30; iReadAddress1 = 8'h05;
    step();
    chk("rst_prio_30", oDataOut0, 16'h0000);
    chk("rst_clr_05", oDataOut1, 16'h0000);
    iReadAddress0 = 8'h06; iReadAddress1 = 8'h20;
    step();
    chk("rst_clr_06", oDataOut0, 16'h0000);
    chk("rst_clr_20", oDataOut1, 16'h0000);

    // Normal operation resumes after reset
    iWriteEnable = 1'b1; iWriteAddress = 8'h7F; iDataIn = 16'h0F0F;
    iReadAddress0 = 8'h7F;
    step();
    chk("post_rst_collide", oDataOut0, 16'h0000);
    iWriteEnable = 1'b0;
    step();
    chk("post_rst_write", oDataOut0, 16'h0F0F);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ram_dual_read_port.md
# ram_dual_read_port

Data memory of the mini-ALU datapath: 256 × 16-bit words with two registered read ports and one synchronous write port. The instruction decoder drives the two source-operand addresses straight from the fetched instruction. The ALU writes results back through the write port. For multiply instructions, an extra write stores the upper 16 bits of the 32-bit product in the word after the destination.

## Interface
Parameters:
- DATA_WIDTH, default 16: word width.
- ADDR_WIDTH, default 8: address width.
- MEM_DEPTH, default 256 (2**ADDR_WIDTH): number of words.

Ports:
- Clock, input, 1: single clock; everything updates on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- iWriteEnable, input, 1: write iDataIn at iWriteAddress.
- iReadAddress0, input, ADDR_WIDTH: read port 0 address.
- iReadAddress1, input, ADDR_WIDTH: read port 1 address.
- iWriteAddress, input, ADDR_WIDTH: primary write address.
- iDataIn, input, DATA_WIDTH: primary write data (low product half on multiply).
- iMulEnable, input, 1: also write iParteAlta at iWriteAddress+1; effective only with iWriteEnable.
- iParteAlta, input, DATA_WIDTH: high product half.
- oDataOut0, output, DATA_WIDTH: registered read data, port 0.
- oDataOut1, output, DATA_WIDTH: registered read data, port 1.

## Operation
- **Reads:** each port registers mem[iReadAddressN] on every rising edge. There is no read enable. The two ports are fully independent and may use the same address.
- **Primary write:** if iWriteEnable=1, mem[iWriteAddress] <= iDataIn.
- **High-part write:** if iWriteEnable=1 and iMulEnable=1, mem[(iWriteAddress+1) mod MEM_DEPTH] <= iParteAlta.
  - Address arithmetic wraps, so write address 255 puts the high half in word 0.
- iMulEnable=1 with iWriteEnable=0 writes nothing.
- **Read-during-write is read-first:** a read of an address written on the same edge returns the old contents. The new value appears on the following read.
- **Reset (Reset=1 at a rising edge):**
  - oDataOut0 and oDataOut1 become 0.
  - All memory words become 0.
  - Any write presented on that edge is discarded; reset has priority.
- Memory and outputs also start at 0 at simulation time 0.
- Unused address bits do not exist: ADDR_WIDTH exactly covers MEM_DEPTH.

## Timing
- Read latency is 1 cycle. An address presented in cycle N produces data on the outputs after edge N, usable in cycle N+1. This matches the decoder's one-cycle opcode register.
- Write latency is 1 cycle. Data written at edge N is readable at edge N+1, so it appears on the output in cycle N+2.
- Outputs hold their value between edges and change only on a clock edge.
- Reset mid-operation takes effect on the same edge; the first post-reset read returns 0.

## Configuration
- Macro RAM_MUL_HIGH_WRITE_EN.
- **Defined:** the high-part write is implemented as described in Operation.
- **Undefined:** the iMulEnable and iParteAlta ports remain but are ignored; only the primary write happens.
- All other behaviour is identical in both builds.

## Structure
- A shared package (the team's definitions file) holds DATA_WIDTH, ADDR_WIDTH and MEM_DEPTH defaults, so the ROM, ALU and RAM agree on widths.
- One sub-module is natural: **reg_sync_reset**, a parameterized-width rising-edge register with synchronous active-high reset and an enable. It is instantiated for each read output register.
- The memory array and write logic live in the top module.

## Test plan
- **Reset:** Reset=1 for 2 cycles with write requests active -> both outputs 0; reading addresses 0x00, 0x7F and 0xFF afterwards returns 0.
- **Write then dual read:** write 0x1234 at addr 0x05 and 0xBEEF at 0x06; then read0=0x05, read1=0x06 -> one cycle later out0=0x1234, out1=0xBEEF. Same address on both ports -> identical data.
- **Read-first collision:** mem[0x10]=0x0001; on one edge, write 0x0002 to 0x10 while reading 0x10 -> output 0x0001; next cycle -> 0x0002.
- **Multiply write (macro defined):** iWriteEnable=1, iMulEnable=1, addr 0x20, iDataIn=0x5678, iParteAlta=0x1234 -> mem[0x20]=0x5678, mem[0x21]=0x1234. Repeat at addr 0xFF -> mem[0xFF] low half, mem[0x00] high half.
- **Multiply gating:** iMulEnable=1, iWriteEnable=0 -> memory unchanged. With the macro undefined, iMulEnable=1 writes only mem[addr] and leaves mem[addr+1] unchanged.
- **Reset priority:** assert Reset on the same edge as a write of 0xAAAA to 0x30 -> mem[0x30] reads 0 after reset.
